// File: rtl/word_egress_serializer_if.sv
// ============================================================================
// word_egress_serializer_if : word-in / byte-out handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface word_egress_serializer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_AW    = 2
);
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  WriteDataValid;
  logic                  Ready;
  logic [7:0]            Data;
  logic                  DataValid;
  logic                  ByteReady;
  logic [FIFO_AW:0]      Level;
  logic                  Overflow;

  // Upstream word source and downstream byte sink, seen from outside the block
  modport master (
    output WriteData, WriteDataValid, ByteReady,
    input  Ready, Data, DataValid, Level, Overflow
  );

  modport slave (
    input  WriteData, WriteDataValid, ByteReady,
    output Ready, Data, DataValid, Level, Overflow
  );
endinterface

`default_nettype wire

// File: rtl/word_egress_serializer.sv
// ============================================================================
// word_egress_serializer : buffered 32-bit word to MSB-first byte egress
// Rev 1.0
// ============================================================================
`default_nettype none

module word_egress_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  wire                       Clk,
  input  wire                       ARst,
  word_egress_serializer_if.slave   bus
);

  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]      wptr_q, rptr_q;
  logic [FIFO_AW:0]        count_q, count_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [1:0]              idx_q, idx_d;
  logic                    ovf_q;
  logic                    ready;
  logic                    push;
  logic                    pop;

  // Ready comes from the registered count only, so a full FIFO refuses a
  // push even on an edge where it also pops.
  assign ready = (count_q != FULL_CNT);
  assign push  = bus.WriteDataValid && ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          idx_d   = 2'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.ByteReady) begin
          if (idx_q == 2'd3) begin
            // Back-to-back words leave no bubble on the byte bus
            if (count_q != '0) begin
              pop     = 1'b1;
              shift_d = mem_q[rptr_q];
              idx_d   = 2'd0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shift_d = shift_q << 8;
            idx_d   = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + (FIFO_AW+1)'(1);
    else if (!push && pop)
      count_d = count_q - (FIFO_AW+1)'(1);
  end

  always_ff @(posedge Clk or negedge ARst) begin
    if (!ARst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      shift_q <= '0;
      idx_q   <= 2'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      if (push)
        wptr_q <= wptr_q + FIFO_AW'(1);
      if (pop)
        rptr_q <= rptr_q + FIFO_AW'(1);
      if (bus.WriteDataValid && !ready)
        ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live
  always_ff @(posedge Clk) begin
    if (push)
      mem_q[wptr_q] <= bus.WriteData;
  end

  assign bus.Ready     = ready;
  assign bus.Data      = shift_q[DATA_WIDTH-1 -: 8];
  assign bus.DataValid = (state_q == SHIFT);
  assign bus.Level     = count_q;
  assign bus.Overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_word_egress_serializer.sv
// ============================================================================
// tb_word_egress_serializer : directed vector bench for the egress serializer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_word_egress_serializer;

  logic clk;
  logic arst_n;
  int   n_chk;
  int   n_err;

  word_egress_serializer_if #(.DATA_WIDTH(32), .FIFO_AW(2)) bus ();

  word_egress_serializer #(
    .DATA_WIDTH(32),
    .FIFO_DEPTH(4),
    .FIFO_AW   (2)
  ) dut (
    .Clk (clk),
    .ARst(arst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wdv;
    logic [31:0] wd;
    logic        br;
    logic        dv;
    logic [7:0]  data;
    logic        rdy;
    logic [2:0]  lvl;
    logic        ovf;
  } vec_t;

  vec_t      vt [15];
  logic [7:0] got [$];
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records every byte taken at each upcoming edge, inputs held constant
  task automatic collect(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      if (bus.DataValid && bus.ByteReady)
        got.push_back(bus.Data);
      tick();
    end
  endtask

  task automatic cmp_bytes(input string name);
    chk({name, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_b%0d", name, i), 64'(got[i]), 64'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  task automatic push_word(input logic [31:0] w);
    bus.WriteDataValid = 1'b1;
    bus.WriteData      = w;
    tick();
    bus.WriteDataValid = 1'b0;
  endtask

  initial begin
    int   nb, nw;
    logic started, gap, saw_full;
    logic [7:0] eb;

    n_chk = 0;
    n_err = 0;
    bus.WriteData      = '0;
    bus.WriteDataValid = 1'b0;
    bus.ByteReady      = 1'b1;
    arst_n             = 1'b0;

    // inputs: wdv, wd, br | expected after the edge: dv, data, rdy, lvl, ovf
    vt[0]  = '{1'b1, 32'hA1B2C3D4, 1'b1, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0};
    vt[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hA1, 1'b1, 3'd0, 1'b0};
    vt[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hB2, 1'b1, 3'd0, 1'b0};
    vt[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hC3, 1'b1, 3'd0, 1'b0};
    vt[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hD4, 1'b1, 3'd0, 1'b0};
    vt[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0};
    vt[6]  = '{1'b1, 32'h11223344, 1'b1, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0};
    vt[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h11, 1'b1, 3'd0, 1'b0};
    vt[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h22, 1'b1, 3'd0, 1'b0};
    vt[9]  = '{1'b0, 32'h0,        1'b0, 1'b1, 8'h22, 1'b1, 3'd0, 1'b0};
    vt[10] = '{1'b0, 32'h0,        1'b0, 1'b1, 8'h22, 1'b1, 3'd0, 1'b0};
    vt[11] = '{1'b0, 32'h0,        1'b0, 1'b1, 8'h22, 1'b1, 3'd0, 1'b0};
    vt[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h33, 1'b1, 3'd0, 1'b0};
    vt[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h44, 1'b1, 3'd0, 1'b0};
    vt[14] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0};

    tick();
    tick();
    arst_n = 1'b1;
    #1;
    chk("reset_state",
        {bus.Data, bus.DataValid, bus.Ready, bus.Level, bus.Overflow},
        {8'h00, 1'b0, 1'b1, 3'd0, 1'b0});

    // Single word and backpressure vectors
    for (int i = 0; i < 15; i++) begin
      bus.WriteDataValid = vt[i].wdv;
      bus.WriteData      = vt[i].wd;
      bus.ByteReady      = vt[i].br;
      tick();
      chk($sformatf("vec%0d", i),
          {bus.DataValid, (vt[i].dv ? bus.Data : 8'h00), bus.Ready, bus.Level, bus.Overflow},
          {vt[i].dv, (vt[i].dv ? vt[i].data : 8'h00), vt[i].rdy, vt[i].lvl, vt[i].ovf});
    end
    bus.WriteDataValid = 1'b0;
    bus.ByteReady      = 1'b1;

    // Burst of six words, pushing whenever Ready allows
    nb = 0; nw = 0; started = 1'b0; gap = 1'b0; saw_full = 1'b0;
    for (int cyc = 0; cyc < 200 && !(nb == 24 && !bus.DataValid); cyc++) begin
      if (bus.DataValid) begin
        started = 1'b1;
        eb = (nb % 4 == 3) ? 8'(nb / 4 + 1) : 8'h00;
        chk($sformatf("burst_b%0d", nb), 64'(bus.Data), 64'(eb));
        nb++;
      end else if (started && nb < 24 && !gap) begin
        gap = 1'b1;
        chk("burst_no_bubble", 64'(nb), 64'd24);
      end
      if (nw < 6 && bus.Ready) begin
        bus.WriteDataValid = 1'b1;
        bus.WriteData      = 32'(nw + 1);
        nw++;
      end else begin
        bus.WriteDataValid = 1'b0;
      end
      tick();
      if (bus.Level == 3'd4) saw_full = 1'b1;
      if (bus.Ready !== (bus.Level != 3'd4))
        chk("burst_ready_vs_level", {bus.Ready, bus.Level}, {(bus.Level != 3'd4), bus.Level});
    end
    bus.WriteDataValid = 1'b0;
    chk("burst_total_bytes", 64'(nb), 64'd24);
    chk("burst_reached_full", 64'(saw_full), 64'd1);

    // Overflow: stall the sink and offer six words back to back
    bus.ByteReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.WriteDataValid = 1'b1;
      bus.WriteData      = {8'h50 + 8'(i), 8'h60 + 8'(i), 8'h70 + 8'(i), 8'h80 + 8'(i)};
      tick();
    end
    bus.WriteDataValid = 1'b0;
    chk("ovf_full", {bus.Level, bus.Ready, bus.Overflow}, {3'd4, 1'b0, 1'b1});
    bus.ByteReady = 1'b1;
    collect(30);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h50 + 8'(i));
      exp_q.push_back(8'h60 + 8'(i));
      exp_q.push_back(8'h70 + 8'(i));
      exp_q.push_back(8'h80 + 8'(i));
    end
    cmp_bytes("ovf_drain");
    chk("ovf_sticky", {bus.Overflow, bus.Level, bus.DataValid}, {1'b1, 3'd0, 1'b0});

    // Reset in the middle of a word
    push_word(32'hDEADBEEF);
    tick();
    tick();
    chk("rst_pre_byte", {bus.DataValid, bus.Data}, {1'b1, 8'hAD});
    #2;
    arst_n = 1'b0;
    #1;
    chk("rst_async",
        {bus.DataValid, bus.Data, bus.Level, bus.Overflow, bus.Ready},
        {1'b0, 8'h00, 3'd0, 1'b0, 1'b1});
    tick();
    arst_n = 1'b1;
    push_word(32'hCAFEF00D);
    collect(10);
    exp_q.push_back(8'hCA); exp_q.push_back(8'hFE);
    exp_q.push_back(8'hF0); exp_q.push_back(8'h0D);
    cmp_bytes("rst_after");

    // Pop and offered push on the same edge while full
    bus.ByteReady = 1'b0;
    for (int i = 0; i < 5; i++) push_word(32'h01020300 + 32'(i));
    bus.ByteReady = 1'b1;
    tick(); tick(); tick();
    chk("full_pre", {bus.Level, bus.Ready, bus.Overflow, bus.Data}, {3'd4, 1'b0, 1'b0, 8'h00});
    bus.WriteDataValid = 1'b1;
    bus.WriteData      = 32'hFFFFFFFF;
    tick();
    bus.WriteDataValid = 1'b0;
    chk("full_push_pop",
        {bus.Level, bus.Ready, bus.Overflow, bus.DataValid, bus.Data},
        {3'd3, 1'b1, 1'b1, 1'b1, 8'h01});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/word_egress_serializer.md
# word_egress_serializer

Buffered word-to-byte egress stage for the stc0 core. It sits directly downstream of the egress stage and accepts 32-bit result words (packed {real[15:0], imag[15:0]}) under a Ready/Valid handshake. It holds them in a small FIFO and serializes each word MSB-byte-first onto the 8-bit chip egress bus. Unlike the plain byte egress path, it also honours a byte-level backpressure input, reports FIFO occupancy, and flags dropped words.

## Interface
Parameters:
- DATA_WIDTH, 32, input word width; fixed at 4 bytes, other values unsupported.
- FIFO_DEPTH, 4, number of word entries in the FIFO; power of two, 2 or more.
- FIFO_AW, 2, log2(FIFO_DEPTH).

Ports:
- Clk  in  1  single clock; all state on rising edge.
- ARst  in  1  reset, asynchronous assert, **active-low** (0 = reset).
- WriteData  in  32  word from the egress stage.
- WriteDataValid  in  1  WriteData valid this cycle.
- Ready  out  1  FIFO can accept a word this cycle.
- Data  out  8  egress byte.
- DataValid  out  1  Data valid this cycle.
- ByteReady  in  1  sink accepts Data this cycle.
- Level  out  FIFO_AW+1  words currently in the FIFO, excluding the word in the shifter.
- Overflow  out  1  sticky flag: a word was offered while Ready=0.

## Operation
- **FIFO**
  - Circular buffer with write and read pointers of FIFO_AW bits, which wrap modulo FIFO_DEPTH, and a count register of FIFO_AW+1 bits.
  - Level = count. Ready = (count != FIFO_DEPTH), decoded from registered count only.
- **Push:** WriteDataValid && Ready. The word is stored at wptr and wptr increments.
- **Drop:** WriteDataValid && !Ready. The word is discarded and Overflow is set to 1. Overflow clears only on reset.
- **Serializer FSM**, states IDLE and SHIFT:
  - The shifter is a 32-bit shift register plus a 2-bit byte index `idx`.
  - Data = shift[31:24] and is registered.
  - A byte is *taken* when DataValid && ByteReady.
- **IDLE → SHIFT:** when count != 0. Pop the word at rptr into shift, set idx=0, set DataValid=1.
- **SHIFT, byte taken, idx<3:** shift <<= 8 and idx++.
- **SHIFT, byte taken, idx==3:**
  - If the FIFO is non-empty, pop the next word directly (idx=0, DataValid stays 1). There is no bubble between words.
  - Otherwise go to IDLE with DataValid=0.
- **SHIFT, ByteReady=0:** Data, DataValid and idx hold unchanged.
- **Simultaneous push and pop:** count is unchanged and both pointers advance.
  - Ready is computed from the pre-edge count. A full FIFO therefore refuses a push even in a cycle where it pops.
- **Empty with a push the same cycle:** the pop waits until the next cycle. There is no bypass, and the word goes through the FIFO.
- **Byte order:** WriteData[31:24], then [23:16], [15:8], [7:0]. That is real MSB, real LSB, imag MSB, imag LSB.
- **Reset (ARst=0), asynchronous at any time, including mid-word:**
  - Clears pointers, count, shift, idx and Overflow, and forces IDLE.
  - In-flight and buffered words are discarded.

## Timing
- **Reset values:** Data=8'h00, DataValid=0, Ready=1, Level=0, Overflow=0.
- **Latency:**
  - A word pushed at edge E0 into an empty FIFO with the FSM in IDLE pops at edge E1.
  - DataValid=1 with byte 0 from E1. With ByteReady=1, bytes 1–3 follow at E2–E4.
- **Throughput:** 1 byte/cycle sustained, 4 cycles/word. Accepted input rate is at most 1 word per 4 cycles once the FIFO is full.
- **Ready timing:** Ready falls in the cycle after the push that makes count==FIFO_DEPTH. It rises in the cycle after the next pop.
- **Level** updates at the same edge as push and pop.

## Test plan
- **Single word:** reset, ByteReady=1, push 32'hA1B2C3D4.
  - DataValid high 4 consecutive cycles starting 1 cycle after the push, with Data=A1,B2,C3,D4.
  - Then DataValid=0 and Level returns to 0.
- **Burst:** push 32'h00000001..32'h00000006 honouring Ready, ByteReady=1.
  - Output is 24 contiguous bytes with no bubble between words: 00,00,00,01,…,00,00,00,06.
  - Ready deasserts once Level=4.
- **Backpressure:** push 32'h11223344, ByteReady=0 for 3 cycles after byte 22 appears.
  - Data holds 8'h22 with DataValid=1 throughout the stall.
  - Sequence resumes 33,44. No byte is lost or duplicated.
- **Overflow:** hold ByteReady=0, push 6 words back-to-back ignoring Ready.
  - Level saturates at 4 and Overflow=1 and stays 1.
  - After releasing ByteReady, exactly the first 5 words are emitted: 4 from the FIFO plus 1 in the shifter.
- **Reset mid-word:** push 32'hDEADBEEF, drop ARst low after byte AD.
  - DataValid goes to 0 immediately (asynchronous). Level=0 and Overflow=0.
  - After release, a push of 32'hCAFEF00D yields CA,FE,F0,0D only.
- **Simultaneous push and pop at full:** with Level=4, a pop and a WriteDataValid occur on the same edge.
  - The word is dropped and Overflow=1, because Ready was 0.
  - Level becomes 3.
